// File: rtl/brick_grid_controller.sv
// brick_grid_controller: destructible-wall map with pixel decode, bullet-hit FSM and level restart.
// Optional STRONG_DOWNGRADE_EN: a strong brick's final hit leaves a plain brick instead of empty.
module brick_grid_controller #(
    parameter int COLS        = 20,
    parameter int ROWS        = 15,
    parameter int GRID_X0     = 0,
    parameter int GRID_Y0     = 0,
    parameter int STRONG_HITS = 3,
    parameter logic [2*COLS*ROWS-1:0] INIT_MAP = '0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        brickInside,
    output logic        strongInside,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    input  logic        hit_req,
    input  logic [4:0]  hit_col,
    input  logic [3:0]  hit_row,
    output logic        hit_ack,
    output logic [1:0]  hit_result,
    input  logic        restart,
    output logic        busy
);
    localparam int N  = COLS * ROWS;
    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {IDLE, LOOKUP, UPDATE, ACK, WAIT_REL, CLEAR} state_t;

    state_t          state_q;
    logic [1:0]      type_q [N];
    logic [1:0]      cnt_q  [N];
    logic [4:0]      col_q;
    logic [3:0]      row_q;
    logic [1:0]      ttype_q, tcnt_q, res_q;
    logic [IW-1:0]   tidx_q, clr_q;
    logic            pend_q, ack_q, busy_q;
    logic            brick_q, strong_q;
    logic [10:0]     ox_q, oy_q;

    logic [10:0]     dx, dy;
    logic            pix_in, hit_ok;
    logic [IW-1:0]   pix_idx, hit_idx;
    logic [1:0]      pix_type;

    always_comb begin
        dx       = pixelX - 11'(GRID_X0);
        dy       = pixelY - 11'(GRID_Y0);
        pix_in   = int'(pixelX) >= GRID_X0 && int'(dx) < 32 * COLS &&
                   int'(pixelY) >= GRID_Y0 && int'(dy) < 32 * ROWS;
        pix_idx  = IW'(int'(dy[10:5]) * COLS + int'(dx[10:5]));
        pix_type = pix_in ? type_q[pix_idx] : 2'd0;
        hit_ok   = int'(col_q) < COLS && int'(row_q) < ROWS;
        hit_idx  = IW'(int'(row_q) * COLS + int'(col_q));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            brick_q  <= 1'b0;
            strong_q <= 1'b0;
            ox_q     <= '0;
            oy_q     <= '0;
        end else begin
            brick_q  <= pix_type == 2'd1;
            strong_q <= pix_type == 2'd2;
            ox_q     <= pix_in ? {6'b0, dx[4:0]} : 11'd0;
            oy_q     <= pix_in ? {6'b0, dy[4:0]} : 11'd0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            ttype_q <= '0;
            tcnt_q  <= '0;
            tidx_q  <= '0;
            clr_q   <= '0;
            res_q   <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                type_q[i] <= INIT_MAP[2*i +: 2];
                cnt_q[i]  <= '0;
            end
        end else begin
            ack_q <= 1'b0;
            // A restart arriving mid-hit is remembered and serviced once the hit retires
            if (restart && state_q != IDLE && state_q != CLEAR)
                pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (restart || pend_q) begin
                        state_q <= CLEAR;
                        pend_q  <= 1'b0;
                        clr_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (hit_req) begin
                        col_q   <= hit_col;
                        row_q   <= hit_row;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    ttype_q <= hit_ok ? type_q[hit_idx] : 2'd0;
                    tcnt_q  <= hit_ok ? cnt_q[hit_idx] : 2'd0;
                    tidx_q  <= hit_idx;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    state_q <= ACK;
                    if (ttype_q == 2'd1) begin
                        type_q[tidx_q] <= 2'd0;
                        res_q          <= 2'd2;
                    end else if (ttype_q == 2'd2 && int'(tcnt_q) < STRONG_HITS - 1) begin
                        cnt_q[tidx_q]  <= tcnt_q + 2'd1;
                        res_q          <= 2'd1;
                    end else if (ttype_q == 2'd2) begin
                        cnt_q[tidx_q]  <= 2'd0;
`ifdef STRONG_DOWNGRADE_EN
                        type_q[tidx_q] <= 2'd1;
                        res_q          <= 2'd3;
`else
                        type_q[tidx_q] <= 2'd0;
                        res_q          <= 2'd2;
`endif
                    end else begin
                        res_q          <= 2'd0;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b1;
                    state_q <= WAIT_REL;
                end
                WAIT_REL: state_q <= hit_req ? WAIT_REL : IDLE;
                CLEAR: begin
                    type_q[clr_q] <= INIT_MAP[2*clr_q +: 2];
                    cnt_q[clr_q]  <= 2'd0;
                    clr_q         <= clr_q + 1'b1;
                    if (clr_q == IW'(N - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign brickInside  = brick_q;
    assign strongInside = strong_q;
    assign offsetX      = ox_q;
    assign offsetY      = oy_q;
    assign hit_ack      = ack_q;
    assign hit_result   = res_q;
    assign busy         = busy_q;
endmodule
